// File: rtl/swc_ob_prio_queue.sv
// Per-port output queue: per-priority circular FIFOs in one RAM, strict-priority registered read port.
// Define SWC_OB_QUEUE_DROP_EN to ack-and-discard writes to a full FIFO instead of backpressuring.
module swc_ob_prio_queue #(
  parameter int g_num_prios        = 8,
  parameter int g_prio_width       = 3,
  parameter int g_page_addr_width  = 10,
  parameter int g_queue_depth_log2 = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,

  input  logic                         tr_data_valid_i,
  output logic                         tr_ack_o,
  input  logic [g_page_addr_width-1:0] tr_pageaddr_i,
  input  logic [g_prio_width-1:0]      tr_prio_i,

  output logic                         rd_valid_o,
  output logic [g_page_addr_width-1:0] rd_pageaddr_o,
  output logic [g_prio_width-1:0]      rd_prio_o,
  input  logic                         rd_ack_i,

  output logic [g_num_prios-1:0]       full_o,
  output logic                         empty_o,
  output logic [15:0]                  drop_cnt_o
);

  localparam int unsigned c_depth     = 1 << g_queue_depth_log2;
  localparam int unsigned c_ram_words = g_num_prios * c_depth;
  localparam int unsigned c_ram_aw    = g_prio_width + g_queue_depth_log2;

  typedef logic [g_queue_depth_log2:0] ptr_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wr_state_t;

  wr_state_t                    state, state_nxt;
  logic                         wr_en;
  ptr_t                         wr_ptr [g_num_prios];
  ptr_t                         rd_ptr [g_num_prios];
  logic [g_num_prios-1:0]       fifo_full;
  logic [g_num_prios-1:0]       fifo_empty;
  logic                         any_ready;
  logic                         load;
  logic [g_prio_width-1:0]      sel;
  logic [c_ram_aw-1:0]          ram_wr_addr;
  logic [c_ram_aw-1:0]          ram_rd_addr;
  logic [g_page_addr_width-1:0] ram_rd_data;
  logic [g_page_addr_width-1:0] mem [c_ram_words];

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    for (int unsigned p = 0; p < g_num_prios; p++) begin
      fifo_empty[p] = (wr_ptr[p] == rd_ptr[p]);
      fifo_full[p]  = (wr_ptr[p][g_queue_depth_log2-1:0] == rd_ptr[p][g_queue_depth_log2-1:0]) &&
                      (wr_ptr[p][g_queue_depth_log2] != rd_ptr[p][g_queue_depth_log2]);
    end
  end

  // ---------------------------------------------------------------- write path
`ifdef SWC_OB_QUEUE_DROP_EN
  logic        drop;
  logic [15:0] drop_cnt;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
`ifdef SWC_OB_QUEUE_DROP_EN
    drop      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (tr_data_valid_i) begin
          if (!fifo_full[tr_prio_i]) begin
            wr_en     = 1'b1;
            state_nxt = ST_ACK;
          end
`ifdef SWC_OB_QUEUE_DROP_EN
          else begin
            drop      = 1'b1;
            state_nxt = ST_ACK;
          end
`endif
        end
      end
      // Valid is ignored here: the arbiter has not yet retired the page just taken.
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tr_ack_o    = (state == ST_ACK);
  assign ram_wr_addr = {tr_prio_i, wr_ptr[tr_prio_i][g_queue_depth_log2-1:0]};

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[ram_wr_addr] <= tr_pageaddr_i;
  end

`ifdef SWC_OB_QUEUE_DROP_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))    drop_cnt <= drop_cnt + 16'd1;
  end
  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

  // ----------------------------------------------------------------- read path
  assign any_ready = ~&fifo_empty;
  assign load      = (!rd_valid_o || rd_ack_i) && any_ready;

  // Ascending scan so the highest-index non-empty FIFO wins.
  always_comb begin
    sel = '0;
    for (int unsigned p = 0; p < g_num_prios; p++) begin
      if (!fifo_empty[p]) sel = g_prio_width'(p);
    end
  end

  assign ram_rd_addr = {sel, rd_ptr[sel][g_queue_depth_log2-1:0]};
  assign ram_rd_data = mem[ram_rd_addr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned p = 0; p < g_num_prios; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < g_num_prios; p++) begin
        if (wr_en && (tr_prio_i == g_prio_width'(p))) wr_ptr[p] <= wr_ptr[p] + ptr_t'(1);
        if (load && (sel == g_prio_width'(p)))        rd_ptr[p] <= rd_ptr[p] + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_o    <= 1'b0;
      rd_pageaddr_o <= '0;
      rd_prio_o     <= '0;
    end else if (load) begin
      rd_valid_o    <= 1'b1;
      rd_pageaddr_o <= ram_rd_data;
      rd_prio_o     <= sel;
    end else if (rd_ack_i) begin
      rd_valid_o    <= 1'b0;
    end
  end

  assign full_o  = fifo_full;
  assign empty_o = !rd_valid_o && (&fifo_empty);

endmodule
